// File: rtl/fifo_pkg.sv
// ============================================================================
//  fifo_pkg
//  Width helpers and parameter legality check shared by the FIFO modules.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int cnt_width(input int depth);
      return addr_width(depth) + 1;
   endfunction

   function automatic bit params_ok(input int depth, input int ae, input int af);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) && (ae < af) && (af <= depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
//  fifo_mem
//  Simple dual-port RAM: synchronous write, registered synchronous read.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 512,
   localparam int ADDR_W    = addr_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [FIFO_WIDTH-1:0] wdata_i,
   input  logic                  rd_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [FIFO_WIDTH-1:0] rdata_o
);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [FIFO_WIDTH-1:0] rdata_q;

   // Storage is never reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
//  sync_fifo_param
//  Single-clock parametrised FIFO with occupancy, threshold flags and
//  registered overflow/underflow pulses.  Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 512,
   parameter int AF_THRESH  = FIFO_DEPTH - 4,
   parameter int AE_THRESH  = 4,
   localparam int ADDR_W    = addr_width(FIFO_DEPTH),
   localparam int CNT_W     = ADDR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr_en,
   input  logic [FIFO_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   generate
      if (!params_ok(FIFO_DEPTH, AE_THRESH, AF_THRESH)) begin : g_param_err
         $error("sync_fifo_param: illegal FIFO_DEPTH/AE_THRESH/AF_THRESH combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, underflow_q;
   logic              wr_acc, rd_acc;

   assign full         = (count_q == C_DEPTH);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= C_AF);
   assign almost_empty = (count_q <= C_AE);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = wr_en & enable & ~full;
   assign rd_acc = rd_en & enable & ~empty;

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= wr_en & enable & full;
         underflow_q <= rd_en & enable & empty;
      end
   end

   fifo_mem #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .rd_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout)
   );

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
//  tb_sync_fifo_param
//  Self-checking bench: queue-based reference model plus directed literals.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int AF = 6;
   localparam int AE = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable, wr_en, rd_en;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   int tests = 0;
   int fails = 0;

   sync_fifo_param #(
      .FIFO_WIDTH (W),
      .FIFO_DEPTH (D),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue, plus last read word and error pulses.
   logic [7:0] mq[$];
   logic [7:0] m_dout;
   logic       m_ovf, m_unf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_dout = 8'h00;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         automatic bit is_full  = (mq.size() == D);
         automatic bit is_empty = (mq.size() == 0);
         automatic bit wa = wr_en && enable && !is_full;
         automatic bit ra = rd_en && enable && !is_empty;
         m_ovf = wr_en && enable && is_full;
         m_unf = rd_en && enable && is_empty;
         if (ra) m_dout = mq.pop_front();
         if (wa) mq.push_back(din);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Continuous compare of every output against the model, away from the edge.
   always @(negedge clk) begin
      automatic int n = mq.size();
      chk("count",        {28'd0, count},        n);
      chk("dout",         {24'd0, dout},         {24'd0, m_dout});
      chk("full",         {31'd0, full},         (n == D) ? 1 : 0);
      chk("empty",        {31'd0, empty},        (n == 0) ? 1 : 0);
      chk("almost_full",  {31'd0, almost_full},  (n >= AF) ? 1 : 0);
      chk("almost_empty", {31'd0, almost_empty}, (n <= AE) ? 1 : 0);
      chk("overflow",     {31'd0, overflow},     {31'd0, m_ovf});
      chk("underflow",    {31'd0, underflow},    {31'd0, m_unf});
   end

   // Drive inputs, take one edge, return 1 time unit after it.
   task automatic step(input logic w, input logic r, input logic e, input logic [7:0] d);
      wr_en  = w;
      rd_en  = r;
      enable = e;
      din    = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] saved;
      int         n0;
      rst = 1'b1; enable = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", {28'd0, count}, 0);
      chk("rst_empty", {31'd0, empty}, 1);
      chk("rst_dout",  {24'd0, dout},  0);
      rst = 1'b0;

      // Reset mid-stream
      step(1, 0, 1, 8'h11);
      step(1, 0, 1, 8'h22);
      step(1, 0, 1, 8'h33);
      step(0, 1, 1, 8'h00);
      chk("mid_dout", {24'd0, dout}, 32'h11);
      wr_en = 1'b1; din = 8'h44;
      #2 rst = 1'b1;
      #1;
      chk("async_count", {28'd0, count}, 0);
      chk("async_empty", {31'd0, empty}, 1);
      chk("async_dout",  {24'd0, dout},  0);
      step(1, 1, 1, 8'h55);
      rst = 1'b0;
      step(0, 1, 1, 8'h00);
      chk("post_rst_unf", {31'd0, underflow}, 1);
      step(0, 0, 1, 8'h00);
      chk("unf_one_cycle", {31'd0, underflow}, 0);

      // Fill and drain
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 1, 8'(i));
         chk("fill_af", {31'd0, almost_full}, (i >= 6) ? 1 : 0);
      end
      chk("fill_full", {31'd0, full}, 1);
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 1, 8'h00);
         chk("drain_dout", {24'd0, dout}, i);
      end
      chk("drain_empty", {31'd0, empty}, 1);

      // Wrap-around
      for (int i = 0; i < 5; i++) step(1, 0, 1, 8'($urandom));
      for (int i = 0; i < 5; i++) step(0, 1, 1, 8'h00);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 8'hA0 + 8'(i));
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, 8'h00);
         chk("wrap_dout", {24'd0, dout}, 32'hA0 + i);
      end

      // Simultaneous read/write at count 4
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h30 + 8'(i));
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1, 8'h40 + 8'(i));
         chk("rw_count", {28'd0, count}, 4);
         chk("rw_dout", {24'd0, dout}, (i < 4) ? (32'h30 + i) : (32'h40 + i - 4));
      end

      // Boundary collisions
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h50 + 8'(i));
      chk("bnd_full", {31'd0, full}, 1);
      step(1, 1, 1, 8'hEE);
      chk("bnd_ovf_count", {28'd0, count}, 7);
      chk("bnd_ovf", {31'd0, overflow}, 1);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 8'h00);
      chk("bnd_empty", {31'd0, empty}, 1);
      saved = m_dout;
      step(1, 1, 1, 8'h77);
      chk("bnd_unf", {31'd0, underflow}, 1);
      chk("bnd_unf_count", {28'd0, count}, 1);
      chk("bnd_unf_dout", {24'd0, dout}, {24'd0, saved});
      step(0, 0, 1, 8'h00);
      chk("bnd_unf_pulse", {31'd0, underflow}, 0);

      // enable low ignores requests
      step(1, 0, 1, 8'h78);
      n0 = mq.size();
      saved = m_dout;
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 8'hC0 + 8'(i));
         chk("dis_count", {28'd0, count}, n0);
         chk("dis_dout", {24'd0, dout}, {24'd0, saved});
         chk("dis_err", {30'd0, overflow, underflow}, 0);
      end
      step(0, 1, 1, 8'h00);
      chk("dis_order", {24'd0, dout}, 32'h77);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0), 8'($urandom));
      end
      step(0, 0, 0, 8'h00);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
